// File: rtl/eight_bit_adder_if.sv
// Operand/result bundle for the ripple-carry adder: the operands and load enable
// come in, and the combinational and registered results go out.
interface eight_bit_adder_if #(
    parameter int N = 8
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         en;
    logic [N-1:0] Sum;
    logic         Cout;
    logic [N-1:0] Sum_r;
    logic         Cout_r;
    logic         Ovf_r;
    logic         Zero_r;
    logic         valid_r;

    modport master (
        output A, B, Cin, en,
        input  Sum, Cout, Sum_r, Cout_r, Ovf_r, Zero_r, valid_r
    );

    modport slave (
        input  A, B, Cin, en,
        output Sum, Cout, Sum_r, Cout_r, Ovf_r, Zero_r, valid_r
    );
endinterface

// File: rtl/eight_bit_adder.sv
// N-bit ripple-carry adder with a combinational sum path and a registered
// result stage that carries carry, signed-overflow and zero flags.
module eight_bit_adder #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    eight_bit_adder_if.slave  bus
);

    logic [N-1:0] sum;
    logic         carry;
    logic         carry_msb;
    logic         ovf;

    // Ripple chain: carry holds c[i] at the start of each step; carry_msb keeps
    // c[N-1], the carry into the sign bit, for the overflow flag.
    always_comb begin
        sum       = '0;
        carry     = bus.Cin;
        carry_msb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) carry_msb = carry;
            sum[i] = bus.A[i] ^ bus.B[i] ^ carry;
            carry  = (bus.A[i] & bus.B[i]) | (carry & (bus.A[i] ^ bus.B[i]));
        end
    end

    assign ovf      = carry ^ carry_msb;
    assign bus.Sum  = sum;
    assign bus.Cout = carry;

    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic         zero_q;
    logic         valid_q;

    // valid_r pulses for the cycle following each enabled edge; the other
    // registered outputs hold their last loaded value while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            sum_q   <= sum;
            cout_q  <= carry;
            ovf_q   <= ovf;
            zero_q  <= (sum == '0);
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.Sum_r   = sum_q;
    assign bus.Cout_r  = cout_q;
    assign bus.Ovf_r   = ovf_q;
    assign bus.Zero_r  = zero_q;
    assign bus.valid_r = valid_q;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Self-checking bench for eight_bit_adder: directed corner cases plus random
// operands compared against an arithmetic reference model.
module tb_eight_bit_adder;

    localparam int N = 8;

    logic clk;
    logic rst_n;

    eight_bit_adder_if #(.N(N)) bus ();

    eight_bit_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // registered-state word: {valid, zero, ovf, cout, sum[7:0]}
    logic [11:0] exp_q[$];
    logic [11:0] model_regs;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_total++;
        if (observed !== expected)
            $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        else
            n_pass++;
    endtask

    // Reference model built on plain integer arithmetic.
    function automatic logic [11:0] ref_load(input int a, input int b, input int cin);
        int total;
        int sa;
        int sb;
        int ss;
        logic [7:0] s8;
        logic zero;
        logic ovf;
        logic cout;
        total = a + b + cin;
        sa    = (a >= 128) ? a - 256 : a;
        sb    = (b >= 128) ? b - 256 : b;
        ss    = sa + sb + cin;
        ovf   = (ss > 127) || (ss < -128);
        cout  = (total >= 256);
        s8    = 8'(total % 256);
        zero  = (total % 256) == 0;
        return {1'b1, zero, ovf, cout, s8};
    endfunction

    task automatic check_regs(input string tag, input logic [11:0] exp_w);
        check({tag, ".sum_r"},   16'(bus.Sum_r),   16'(exp_w[7:0]));
        check({tag, ".cout_r"},  16'(bus.Cout_r),  16'(exp_w[8]));
        check({tag, ".ovf_r"},   16'(bus.Ovf_r),   16'(exp_w[9]));
        check({tag, ".zero_r"},  16'(bus.Zero_r),  16'(exp_w[10]));
        check({tag, ".valid_r"}, 16'(bus.valid_r), 16'(exp_w[11]));
    endtask

    // driver: called just after a negedge; returns at the next negedge
    task automatic apply(input string tag, input int a, input int b, input int cin, input logic en);
        int total;
        logic [11:0] exp_w;
        bus.A   = 8'(a);
        bus.B   = 8'(b);
        bus.Cin = cin[0];
        bus.en  = en;
        total   = a + b + cin;
        #1;
        check({tag, ".sum"},  16'(bus.Sum),  16'(total % 256));
        check({tag, ".cout"}, 16'(bus.Cout), 16'(total >= 256));
        @(posedge clk);
        if (en) model_regs = ref_load(a, b, cin);
        else    model_regs[11] = 1'b0;
        exp_q.push_back(model_regs);
        #1;
        exp_w = exp_q.pop_front();
        check_regs(tag, exp_w);
        @(negedge clk);
    endtask

    initial begin
        int a;
        int b;
        int c;
        n_pass     = 0;
        n_total    = 0;
        model_regs = '0;
        rst_n      = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.Cin    = 1'b0;
        bus.en     = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_regs("reset", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        apply("t1",      100,  27, 0, 1'b1);
        apply("t2",      127, 127, 1, 1'b1);
        apply("t3",      128, 128, 0, 1'b1);
        apply("t4a",     255, 255, 1, 1'b1);
        apply("t4b",     255,   0, 1, 1'b1);
        apply("b2b",      10,  20, 1, 1'b1);

        // random low range: never carries out
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, 127);
            b = $urandom_range(0, 127);
            c = $urandom_range(0, 1);
            apply("rnd_lo", a, b, c, 1'b1);
            check("rnd_lo.nocarry", 16'(bus.Cout), 16'(0));
        end

        // random high range: always carries out
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(128, 255);
            b = $urandom_range(128, 255);
            c = $urandom_range(0, 1);
            apply("rnd_hi", a, b, c, 1'b1);
            check("rnd_hi.carry", 16'(bus.Cout), 16'(1));
        end

        // fully random operands with random enable
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            c = $urandom_range(0, 1);
            apply("rnd", a, b, c, 1'($urandom_range(0, 1)));
        end

        // load then hold for three cycles with changing operands
        apply("hold_ld", 200, 100, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            apply("hold", a, b, 0, 1'b0);
        end

        // asynchronous reset between edges after a load
        apply("pre_rst", 50, 60, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_regs = '0;
        check_regs("async_rst", 12'h000);
        check("async_rst.sum", 16'(bus.Sum), 16'(110));

        // reset wins over an enabled edge
        bus.A  = 8'd5;
        bus.B  = 8'd6;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        check_regs("rst_en", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        apply("post_rst", 1, 2, 0, 1'b1);
        check("post_rst.three", 16'(bus.Sum_r), 16'(3));
        apply("idle", 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eight_bit_adder.md
Name: eight_bit_adder

Overview:
Parameterised N-bit ripple-carry adder with carry-in and carry-out. It provides a combinational sum path and a registered result stage with status flags. It is the arithmetic core of the mini-calculator datapath and feeds the result/flag registers read by the control logic.

Parameters:
N, 8, operand and sum width in bits (N >= 2).

Ports:
clk  input  1  rising-edge clock for the registered result stage.
rst_n  input  1  asynchronous active-low reset; clears all registered outputs.
A  input  N  unsigned operand A.
B  input  N  unsigned operand B.
Cin  input  1  carry-in.
Sum  output  N  combinational sum, low N bits of A+B+Cin.
Cout  output  1  combinational carry-out, bit N of A+B+Cin.
en  input  1  load enable for the registered stage.
Sum_r  output  N  registered Sum.
Cout_r  output  1  registered Cout.
Ovf_r  output  1  registered two's-complement signed overflow.
Zero_r  output  1  registered flag, 1 when the registered Sum is 0.
valid_r  output  1  1 for the cycle after a load, otherwise 0.

Behaviour:
- Combinational path:
  - {Cout,Sum} == A + B + Cin, exact for all operand values, evaluated at N+1 bits.
  - Built as a chain of N full adders: c[0]=Cin; s[i]=A[i]^B[i]^c[i]; c[i+1]=(A[i]&B[i])|(c[i]&(A[i]^B[i])); Cout=c[N].
  - No clock dependence; outputs settle within one propagation delay of any input change.
- Ranges for N=8:
  - A,B <= 127 never produce carry-out (max 127+127+1=255).
  - A,B >= 128 always produce Cout=1.
  - Wrap-around: 255+0+1 gives Sum=0, Cout=1.
- Signed overflow: ovf = c[N] ^ c[N-1], equivalently both operands have the same MSB and Sum MSB differs.
- Registered stage, on rising clk when rst_n=1:
  - en=1: Sum_r<=Sum, Cout_r<=Cout, Ovf_r<=ovf, Zero_r<=(Sum==0), valid_r<=1.
  - en=0: Sum_r, Cout_r, Ovf_r and Zero_r hold their values; valid_r<=0.
- Latency: registered outputs reflect the inputs sampled at the enabled edge one clock later. valid_r is a single-cycle pulse per load; back-to-back enables keep valid_r=1.
- Reset:
  - rst_n=0 immediately, without waiting for clk, forces Sum_r=0, Cout_r=0, Ovf_r=0, Zero_r=0 and valid_r=0.
  - Zero_r resets to 0 because no result is valid yet.
  - Combinational Sum/Cout are unaffected by reset.
  - Reset asserted mid-operation discards the pending load.
  - On release, the first enabled edge loads normally. Deassertion is synchronised by the system reset controller.
- Simultaneous reset and en=1: reset wins.
- No internal state other than the result registers; no X propagation from idle inputs into the held registers.

Test Plan:
1. A=100, B=27, Cin=0 -> Sum=127, Cout=0; after enabled edge Sum_r=127, Cout_r=0, Ovf_r=0, Zero_r=0, valid_r=1.
2. A=127, B=127, Cin=1 -> Sum=255, Cout=0, Ovf=1. Also randomised A,B in [0:127] with random Cin -> Cout=0 and {Cout,Sum}==A+B+Cin.
3. A=128, B=128, Cin=0 -> Sum=0, Cout=1, Ovf_r=1, Zero_r=1. Also randomised A,B in [128:255] -> Cout=1 always and {Cout,Sum}==A+B+Cin.
4. A=255, B=255, Cin=1 -> Sum=255, Cout=1. A=255, B=0, Cin=1 -> Sum=0, Cout=1, Zero_r=1, Ovf_r=0.
5. Load with en=1, then hold en=0 for 3 cycles while changing A/B -> Sum_r/Cout_r unchanged, valid_r=0 after the first hold cycle.
6. Assert rst_n=0 between clock edges after a load -> all registered outputs 0 immediately. Assert with en=1 at an edge -> registers stay 0. Release and load A=1, B=2, Cin=0 -> Sum_r=3.
